// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pipe
//  Purpose  : Pipelined signed fixed-point (two's complement, Q-format)
//             multiplier with valid/ready handshake, per-operation rounding,
//             selectable saturate/wrap and sticky overflow status.
//  Ports    : clk, rst (async, active-low)
//             in_valid / in_ready / a_in / b_in / rnd_mode : operand side
//             out_valid / out_ready / mult_out / overflow  : result side
//             ovf_sticky / clr_ovf                         : overflow status
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int N    = 16,
  parameter int Q    = 12,
  parameter int PIPE = 3,
  parameter int SAT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] mult_out,
  output logic         overflow,
  output logic         ovf_sticky,
  input  logic         clr_ovf
);

  localparam int PW = 2 * N;      // exact product width
  localparam int RW = 2 * N + 1;  // rounding width, one guard bit so +half never wraps

  localparam logic [RW-1:0] c_rnd_half = {{(RW-1){1'b0}}, 1'b1} << (Q - 1);
  localparam logic [N-1:0]  c_max      = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  c_min      = {1'b1, {(N-1){1'b0}}};

  // Exact 2N-bit signed product; operands sign-extended so the multiply is
  // carried out at full width regardless of context sizing.
  function automatic logic [PW-1:0] mul_full(input logic [N-1:0] a,
                                             input logic [N-1:0] b);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = $signed({{N{a[N-1]}}, a});
    bx = $signed({{N{b[N-1]}}, b});
    return ax * bx;
  endfunction

  // Rescale by 2^-Q with optional round-half-up, then range check and
  // saturate/wrap. Returns {overflow, value}.
  function automatic logic [N:0] finish(input logic [PW-1:0] p,
                                        input logic          rnd);
    logic signed [RW-1:0] s;
    logic signed [RW-1:0] r;
    logic [RW-N:0]        hi;
    logic                 ovf;
    logic [N-1:0]         val;
    s   = {p[PW-1], p} + (rnd ? c_rnd_half : {RW{1'b0}});
    r   = s >>> Q;
    // In range only when every bit from the result sign upward agrees.
    hi  = r[RW-1:N-1];
    ovf = ~((&hi) | ~(|hi));
    if (ovf && (SAT != 0)) begin
      val = r[RW-1] ? c_min : c_max;
    end else begin
      val = r[N-1:0];
    end
    return {ovf, val};
  endfunction

  // --------------------------------------------------------------------------
  // Handshake: the whole pipe freezes while the output is held by downstream.
  // --------------------------------------------------------------------------
  logic [PIPE-1:0] r_vld;
  logic [PIPE:0]   w_vld_shift;
  logic            w_stall;
  logic            w_adv;
  logic [N:0]      w_res;   // {overflow, value} of the last stage

  assign out_valid   = r_vld[PIPE-1];
  assign w_stall     = out_valid & ~out_ready;
  assign w_adv       = ~w_stall;
  assign in_ready    = ~w_stall;
  assign w_vld_shift = {r_vld, in_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= w_vld_shift[PIPE-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath. Stage 1 captures operands; the multiply, the round/saturate and
  // any extra latency are spread over the remaining stages.
  // --------------------------------------------------------------------------
  generate
    if (PIPE == 1) begin : g_pipe1
      logic [N:0] r_res;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_res <= '0;
        end else if (w_adv) begin
          r_res <= finish(mul_full(a_in, b_in), rnd_mode);
        end
      end
      assign w_res = r_res;
    end else if (PIPE == 2) begin : g_pipe2
      logic [N-1:0] r_s1_a;
      logic [N-1:0] r_s1_b;
      logic         r_s1_rnd;
      logic [N:0]   r_res;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s1_a   <= '0;
          r_s1_b   <= '0;
          r_s1_rnd <= 1'b0;
          r_res    <= '0;
        end else if (w_adv) begin
          r_s1_a   <= a_in;
          r_s1_b   <= b_in;
          r_s1_rnd <= rnd_mode;
          r_res    <= finish(mul_full(r_s1_a, r_s1_b), r_s1_rnd);
        end
      end
      assign w_res = r_res;
    end else begin : g_pipen
      logic [N-1:0]  r_s1_a;
      logic [N-1:0]  r_s1_b;
      logic          r_s1_rnd;
      logic [PW-1:0] r_s2_p;
      logic          r_s2_rnd;
      // r_stg[2] holds the finished result; higher indices only add latency.
      logic [N:0]    r_stg [2:PIPE-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s1_a   <= '0;
          r_s1_b   <= '0;
          r_s1_rnd <= 1'b0;
          r_s2_p   <= '0;
          r_s2_rnd <= 1'b0;
          for (int k = 2; k < PIPE; k++) begin
            r_stg[k] <= '0;
          end
        end else if (w_adv) begin
          r_s1_a   <= a_in;
          r_s1_b   <= b_in;
          r_s1_rnd <= rnd_mode;
          r_s2_p   <= mul_full(r_s1_a, r_s1_b);
          r_s2_rnd <= r_s1_rnd;
          r_stg[2] <= finish(r_s2_p, r_s2_rnd);
          for (int k = 3; k < PIPE; k++) begin
            r_stg[k] <= r_stg[k-1];
          end
        end
      end
      assign w_res = r_stg[PIPE-1];
    end
  endgenerate

  assign mult_out = w_res[N-1:0];
  assign overflow = w_res[N];

  // Set has priority over clear so an overflow emitted alongside a clear is
  // never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && overflow) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_pipe
//  Purpose  : Self-checking bench for fp_mul_pipe (N=16, Q=12, PIPE=3).
//             One instance saturates, a second wraps; both share stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_pipe;

  localparam int N    = 16;
  localparam int Q    = 12;
  localparam int PIPE = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         rnd_mode = 1'b0;
  logic         out_ready = 1'b1;
  logic         clr_ovf = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;

  logic         in_ready, out_valid, overflow, ovf_sticky;
  logic [N-1:0] mult_out;
  logic         in_ready_w, out_valid_w, overflow_w, ovf_sticky_w;
  logic [N-1:0] mult_out_w;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.N(N), .Q(Q), .PIPE(PIPE), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .mult_out(mult_out),
    .overflow(overflow), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  fp_mul_pipe #(.N(N), .Q(Q), .PIPE(PIPE), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a_in(a_in), .b_in(b_in), .rnd_mode(rnd_mode),
    .out_valid(out_valid_w), .out_ready(out_ready), .mult_out(mult_out_w),
    .overflow(overflow_w), .ovf_sticky(ovf_sticky_w), .clr_ovf(clr_ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rnd;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference arithmetic in 64-bit integers: {overflow, value}.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic rnd, input bit sat);
    longint      p;
    longint      r;
    logic        ovf;
    logic [15:0] v;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd) p = p + 2048;
    r = p >>> 12;
    ovf = (r > 32767) || (r < -32768);
    v = r[15:0];
    if (ovf && sat) v = (r < 0) ? 16'h8000 : 16'h7FFF;
    return {ovf, v};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [16:0] eq_s[$];
    logic [16:0] eq_w[$];
    logic [16:0] es, ew;
    int          lat, sent, got;
    bit          acc, prev_stall, seen;
    logic [15:0] prev_out;
    logic        prev_ovf;

    vecs[0] = '{16'h1800, 16'h2000, 1'b0, 16'h3000, 16'h3000, 1'b0};
    vecs[1] = '{16'hE800, 16'h2000, 1'b0, 16'hD000, 16'hD000, 1'b0};
    vecs[2] = '{16'h8000, 16'hF000, 1'b0, 16'h7FFF, 16'h8000, 1'b1};
    vecs[3] = '{16'h0001, 16'h0800, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{16'h0001, 16'h0800, 1'b1, 16'h0001, 16'h0001, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0800, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{16'hFFFF, 16'h0800, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h8000, 16'h2000, 1'b0, 16'h8000, 16'h0000, 1'b1};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset mult_out", mult_out, 0);
    chk("reset overflow", overflow, 0);
    chk("reset ovf_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", in_ready, 1);

    // ---------------- directed vectors, one at a time ----------------
    // lat counts rising edges starting with the transfer edge itself.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_in = vecs[i].a; b_in = vecs[i].b; rnd_mode = vecs[i].rnd; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("vec%0d latency", i), lat, PIPE);
      chk($sformatf("vec%0d sat value", i), mult_out, vecs[i].exp_sat);
      chk($sformatf("vec%0d sat overflow", i), overflow, vecs[i].exp_ovf);
      chk($sformatf("vec%0d wrap value", i), mult_out_w, vecs[i].exp_wrap);
      chk($sformatf("vec%0d wrap overflow", i), overflow_w, vecs[i].exp_ovf);
    end
    @(posedge clk);
    #1;
    chk("sticky after overflow", ovf_sticky, 1);
    chk("sticky wrap after overflow", ovf_sticky_w, 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    #1;
    chk("sticky cleared", ovf_sticky, 0);

    // ---------------- streaming with backpressure ----------------
    sent = 0; got = 0; prev_stall = 1'b0; prev_out = '0; prev_ovf = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      if (!in_valid && sent < 20) begin
        a_in = 16'($urandom); b_in = 16'($urandom);
        rnd_mode = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      end
      #1;
      if (prev_stall) begin
        chk("hold out_valid", out_valid, 1);
        chk("hold mult_out", mult_out, prev_out);
        chk("hold overflow", overflow, prev_ovf);
      end
      chk("in_ready vs stall", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (eq_s.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          es = eq_s.pop_front();
          ew = eq_w.pop_front();
          chk($sformatf("stream%0d sat", got), {overflow, mult_out}, es);
          chk($sformatf("stream%0d wrap", got), {overflow_w, mult_out_w}, ew);
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        eq_s.push_back(model(a_in, b_in, rnd_mode, 1'b1));
        eq_w.push_back(model(a_in, b_in, rnd_mode, 1'b0));
      end
      prev_stall = out_valid && !out_ready;
      prev_out = mult_out;
      prev_ovf = overflow;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("stream result count", got, 20);
    chk("stream queue drained", eq_s.size(), 0);

    // ---------------- reset with three operations in flight ----------------
    @(negedge clk);
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a_in = 16'h8000; b_in = 16'hF000; rnd_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("in flight before reset", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("reset mid-stream out_valid", out_valid, 0);
    chk("reset mid-stream mult_out", mult_out, 0);
    chk("reset mid-stream overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after mid reset", in_ready, 1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid || out_valid_w) seen = 1'b1;
    end
    chk("no stale result after reset", seen, 0);
    chk("sticky after mid reset", ovf_sticky, 0);

    // ---------------- clr_ovf coincident with overflow emit ----------------
    @(negedge clk);
    a_in = 16'h8000; b_in = 16'hF000; rnd_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("overflow op emerged", out_valid, 1);
    chk("overflow op flag", overflow, 1);
    chk("sticky before emit", ovf_sticky, 0);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("set wins over clear", ovf_sticky, 1);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    chk("clear without emit", ovf_sticky, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
